// File: rtl/weight_display_driver_pkg.sv
// Shared types and constants for the weight display driver: FSM states,
// active-low segment patterns and the double-dabble adjust step.
package weight_display_driver_pkg;

    localparam int BIN_W    = 14;
    localparam int BCD_W    = 20;
    localparam int DIGITS   = 5;
    localparam int DP_DIGIT = 3;

    localparam logic [3:0] CONV_LAST = 4'(BIN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CONV_INT  = 2'd1,
        ST_CONV_FRAC = 2'd2,
        ST_COMMIT    = 2'd3
    } state_e;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else                       r[4*i +: 4] = bcd[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_display_driver_bcd_to_seg7.sv
// BCD digit to active-low 7-segment pattern; codes above 9 and blank_i give an unlit digit.
module weight_display_driver_bcd_to_seg7
    import weight_display_driver_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/weight_display_driver.sv
// Converts kg integer/fraction to BCD serially, commits "II.FFF" atomically to a
// display buffer, and scans it onto a 5-digit multiplexed active-low display.
module weight_display_driver
    import weight_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  weightInKilogramsInteger,
    input  logic [BIN_W-1:0]  weightInKilogramsFraction,
    input  logic              loadStrobe,
    output logic              busy,
    output logic              overRange,
    output logic [DIGITS-1:0] anodes,
    output logic [6:0]        segments,
    output logic              decimalPoint
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

    state_e                   state_q, state_d;
    logic [BIN_W-1:0]         bin_q, bin_d;
    logic [BIN_W-1:0]         frac_q, frac_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [BCD_W-1:0]         int_bcd_q, int_bcd_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [DIGITS-1:0][3:0]   buf_q, buf_d;
    logic                     over_q, over_d;
    logic [RW-1:0]            refresh_q, refresh_d;
    logic [2:0]               idx_q, idx_d;
    logic [DIGITS-1:0]        anodes_q, anodes_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_q, dp_d;

    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_step;
    logic [3:0]       cur_digit;
    logic             cur_blank;
    logic [6:0]       dec_seg;

    assign bcd_adj  = dabble_adjust(bcd_q);
    assign bcd_step = (bcd_adj << 1) | BCD_W'(bin_q[BIN_W-1]);

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        frac_d    = frac_q;
        bcd_d     = bcd_q;
        int_bcd_d = int_bcd_q;
        bit_cnt_d = bit_cnt_q;
        buf_d     = buf_q;
        over_d    = over_q;
        case (state_q)
            ST_IDLE: begin
                if (loadStrobe) begin
                    bin_d     = weightInKilogramsInteger;
                    frac_d    = weightInKilogramsFraction;
                    bcd_d     = '0;
                    bit_cnt_d = CONV_LAST;
                    state_d   = ST_CONV_INT;
                end
            end
            ST_CONV_INT: begin
                bcd_d     = bcd_step;
                bin_d     = bin_q << 1;
                bit_cnt_d = bit_cnt_q - 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    // integer result parked; the shift register is reused for the fraction
                    int_bcd_d = bcd_step;
                    bcd_d     = '0;
                    bin_d     = frac_q;
                    bit_cnt_d = CONV_LAST;
                    state_d   = ST_CONV_FRAC;
                end
            end
            ST_CONV_FRAC: begin
                bcd_d     = bcd_step;
                bin_d     = bin_q << 1;
                bit_cnt_d = bit_cnt_q - 4'd1;
                if (bit_cnt_q == 4'd0) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                over_d  = (|int_bcd_q[BCD_W-1:8]) | (|bcd_q[BCD_W-1:12]);
                buf_d   = {int_bcd_q[7:4], int_bcd_q[3:0], bcd_q[11:8], bcd_q[7:4], bcd_q[3:0]};
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cur_digit = buf_q[idx_q];
    assign cur_blank = (idx_q == 3'(DIGITS - 1)) && (cur_digit == 4'd0);

    weight_display_driver_bcd_to_seg7 u_dec (
        .bcd_i   (cur_digit),
        .blank_i (cur_blank),
        .seg_o   (dec_seg)
    );

    always_comb begin
        refresh_d = refresh_q + RW'(1);
        idx_d     = idx_q;
        if (refresh_q == REFRESH_MAX) begin
            refresh_d = '0;
            idx_d     = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        anodes_d = ~(DIGITS'(1) << idx_q);
        seg_d    = over_q ? SEG_DASH : dec_seg;
        dp_d     = !((idx_q == 3'(DP_DIGIT)) && !over_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            frac_q    <= '0;
            bcd_q     <= '0;
            int_bcd_q <= '0;
            bit_cnt_q <= '0;
            buf_q     <= '0;
            over_q    <= 1'b0;
            refresh_q <= '0;
            idx_q     <= '0;
            anodes_q  <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            frac_q    <= frac_d;
            bcd_q     <= bcd_d;
            int_bcd_q <= int_bcd_d;
            bit_cnt_q <= bit_cnt_d;
            buf_q     <= buf_d;
            over_q    <= over_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            anodes_q  <= anodes_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign overRange    = over_q;
    assign anodes       = anodes_q;
    assign segments     = seg_q;
    assign decimalPoint = dp_q;

endmodule
